// File: rtl/regfile_write_scheduler_pkg.sv
// Shared constants and types for the register-file write scheduler.
package regfile_write_scheduler_pkg;

    localparam int WORD      = 64;
    localparam int ZERO_REG  = 31;
    localparam int REG_IDX_W = 5;
    localparam int NUM_REGS  = 32;

    // Identifies which writeback requester won the last accepted transfer.
    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_e;

endpackage

// File: rtl/regfile_write_scheduler_if.sv
// Writeback requests, reservation/hazard lookup and register-file write port.
interface regfile_write_scheduler_if #(
    parameter int WIDTH = regfile_write_scheduler_pkg::WORD
);
    import regfile_write_scheduler_pkg::*;

    logic                 alu_valid;
    logic                 alu_ready;
    logic [REG_IDX_W-1:0] alu_reg;
    logic [WIDTH-1:0]     alu_data;

    logic                 mem_valid;
    logic                 mem_ready;
    logic [REG_IDX_W-1:0] mem_reg;
    logic [WIDTH-1:0]     mem_data;

    logic                 reserve_valid;
    logic [REG_IDX_W-1:0] reserve_reg;
    logic [REG_IDX_W-1:0] check_reg1;
    logic [REG_IDX_W-1:0] check_reg2;
    logic                 hazard;

    logic                 reg_write;
    logic [REG_IDX_W-1:0] write_reg;
    logic [WIDTH-1:0]     write_data;
    logic [NUM_REGS-1:0]  pending;

    // Pipeline side: presents requests, reservations and source checks.
    modport master (
        output alu_valid, alu_reg, alu_data,
        output mem_valid, mem_reg, mem_data,
        output reserve_valid, reserve_reg, check_reg1, check_reg2,
        input  alu_ready, mem_ready, hazard,
        input  reg_write, write_reg, write_data, pending
    );

    // Scheduler side.
    modport slave (
        input  alu_valid, alu_reg, alu_data,
        input  mem_valid, mem_reg, mem_data,
        input  reserve_valid, reserve_reg, check_reg1, check_reg2,
        output alu_ready, mem_ready, hazard,
        output reg_write, write_reg, write_data, pending
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared after
// the committed write cycle; answers read-after-write hazard queries.
module regfile_scoreboard #(
    parameter int ZERO_REG = regfile_write_scheduler_pkg::ZERO_REG
) (
    input  logic                                              clk,
    input  logic                                              reset,
    input  logic                                              set_valid_i,
    input  logic [regfile_write_scheduler_pkg::REG_IDX_W-1:0] set_reg_i,
    input  logic                                              clr_valid_i,
    input  logic [regfile_write_scheduler_pkg::REG_IDX_W-1:0] clr_reg_i,
    input  logic [regfile_write_scheduler_pkg::REG_IDX_W-1:0] check_reg1_i,
    input  logic [regfile_write_scheduler_pkg::REG_IDX_W-1:0] check_reg2_i,
    output logic [regfile_write_scheduler_pkg::NUM_REGS-1:0]  pending_o,
    output logic                                              hazard_o
);
    import regfile_write_scheduler_pkg::*;

    localparam logic [REG_IDX_W-1:0] ZERO_IDX = REG_IDX_W'(ZERO_REG);

    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;

    // Next pending vector: clear first so a same-edge set (new producer) wins.
    always_comb begin
        // NOTE: start every combinational output from a default so no path leaves it unassigned (no latch).
        pending_d = pending_q;
        if (clr_valid_i) begin
            pending_d[clr_reg_i] = 1'b0;
        end
        if (set_valid_i && (set_reg_i != ZERO_IDX)) begin
            pending_d[set_reg_i] = 1'b1;
        end
    end

    // Scoreboard state register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
        if (reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending_o = pending_q;
    assign hazard_o  = ((check_reg1_i != ZERO_IDX) && pending_q[check_reg1_i]) ||
                       ((check_reg2_i != ZERO_IDX) && pending_q[check_reg2_i]);

endmodule

// File: rtl/regfile_write_scheduler.sv
// Round-robin arbiter sharing the register-file write port between ALU and
// load writeback, with registered write outputs and a pending-write scoreboard.
module regfile_write_scheduler #(
    parameter int WIDTH    = regfile_write_scheduler_pkg::WORD,
    parameter int ZERO_REG = regfile_write_scheduler_pkg::ZERO_REG
) (
    input  logic                      clk,
    input  logic                      reset,
    regfile_write_scheduler_if.slave  bus
);
    import regfile_write_scheduler_pkg::*;

    localparam logic [REG_IDX_W-1:0] ZERO_IDX = REG_IDX_W'(ZERO_REG);

    logic                 grant_alu;
    logic                 grant_mem;
    logic                 xfer;
    logic [REG_IDX_W-1:0] sel_reg;
    logic [WIDTH-1:0]     sel_data;

    req_e                 last_grant_q, last_grant_d;
    logic                 reg_write_q,  reg_write_d;
    logic [REG_IDX_W-1:0] write_reg_q,  write_reg_d;
    logic [WIDTH-1:0]     write_data_q, write_data_d;

    // Grant selection: a lone requester wins; a tie goes to the one not granted last.
    always_comb begin
        grant_alu = 1'b0;
        grant_mem = 1'b0;
        if (!reset) begin
            if (bus.alu_valid && (!bus.mem_valid || (last_grant_q == REQ_MEM))) begin
                grant_alu = 1'b1;
            end else if (bus.mem_valid) begin
                grant_mem = 1'b1;
            end
        end
    end

    assign xfer     = grant_alu || grant_mem;
    assign sel_reg  = grant_mem ? bus.mem_reg  : bus.alu_reg;
    assign sel_data = grant_mem ? bus.mem_data : bus.alu_data;

    // Next state for the round-robin pointer and the write-port registers.
    always_comb begin
        last_grant_d = last_grant_q;
        reg_write_d  = 1'b0;
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;
        if (xfer) begin
            last_grant_d = grant_mem ? REQ_MEM : REQ_ALU;
            // A write to XZR is accepted but never reaches the register file.
            reg_write_d  = (sel_reg != ZERO_IDX);
            write_reg_d  = sel_reg;
            write_data_d = sel_data;
        end
    end

    // Pointer and write-port registers; reset drops any in-flight write.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= REQ_MEM;
            reg_write_q  <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            reg_write_q  <= reg_write_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
        end
    end

    assign bus.alu_ready  = grant_alu;
    assign bus.mem_ready  = grant_mem;
    assign bus.reg_write  = reg_write_q;
    assign bus.write_reg  = write_reg_q;
    assign bus.write_data = write_data_q;

    // Pending bits clear only after the reg_write cycle has fully elapsed.
    regfile_scoreboard #(
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk          (clk),
        .reset        (reset),
        .set_valid_i  (bus.reserve_valid),
        .set_reg_i    (bus.reserve_reg),
        .clr_valid_i  (reg_write_q),
        .clr_reg_i    (write_reg_q),
        .check_reg1_i (bus.check_reg1),
        .check_reg2_i (bus.check_reg2),
        .pending_o    (bus.pending),
        .hazard_o     (bus.hazard)
    );

endmodule
